clk_div_n: RTL and testbench
============================

# clk_div_n

Parametrised, runtime-programmable integer clock divider: the generalised successor to the fixed divide-by-5 block. It divides `clk` by any programmable N ≥ 2 with exactly 50 % duty for both even and odd N. Divisor changes apply only at period boundaries, and an enable stops the output cleanly. It sits in the clocking area, feeding slow peripheral clocks and sample strobes.

## Interface
- `WIDTH`, default 8: divisor and counter width; max divisor 2^WIDTH−1.
- `RESET_DIV`, default 5: active divisor after reset; must satisfy 2 ≤ RESET_DIV ≤ 2^WIDTH−1.
- `clk`  in  1: the only clock; `clk_out` is derived from it.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: run request, sampled on posedge `clk`.
- `div`  in  WIDTH: requested divisor.
- `load`  in  1: one-cycle strobe; captures `div` into the pending register.
- `clk_out`  out  1: divided clock.
- `tick`  out  1: one `clk`-cycle pulse coincident with each `clk_out` rising edge.
- `running`  out  1: high while periods are being generated.
- `div_err`  out  1: sticky; set when a loaded `div` < 2.

## Operation
- Counter `cnt` counts 0..N−1 and wraps to 0. `cnt == 0` is the period start.
- H = floor(N/2).
- Posedge term `hi_pos` = (`cnt` < H) for even N and (`cnt` < H) for odd N; both use the same rule, registered.
- Odd N, macro defined: a negedge flop copies `hi_pos`. `clk_out = hi_pos | hi_neg` extends the high phase by half a cycle, so high = N/2 cycles exactly.
- Even N: `clk_out = hi_pos`, and the negedge term is forced 0.
- `load`: `div` goes into `pend`, and `pend_valid` is set. If `div` < 2, store 2 and set `div_err`.
- A new `load` before application overwrites `pend`; last write wins.
- `pend` transfers to the active divisor only when `cnt` wraps to 0, or at start-up from idle. A period in flight always completes at the old N, so no runt or stretched pulse appears.
- `load` coincident with a wrap edge is applied at the following wrap, not the current one.
- `div_err` clears on reset only.
- Idle → Run: `en` sampled high while idle. Set `cnt` = 0 and `running` = 1, and apply any pending divisor.
- Run → Idle: `en` sampled low. Finish the current period; at the wrap, `running` = 0, `cnt` holds 0, and `clk_out` stays low.
- Re-asserting `en` during the finishing period cancels the stop, and the output continues seamlessly.

## Timing
- Reset values: `cnt`=0, active divisor=RESET_DIV, `pend_valid`=0, `clk_out`=0, `hi_pos`=0, `hi_neg`=0, `tick`=0, `running`=0, `div_err`=0.
- `rst` asserted mid-period forces all outputs to their reset values immediately. A truncated pulse is accepted.
- First edge: `en` sampled high at posedge k gives `clk_out` and `tick` high after posedge k.
- Period: `clk_out` period = N `clk` cycles. Rising edges are posedge-aligned. For odd N with the macro defined, falling edges are negedge-aligned.
- `tick` is registered and high for exactly one cycle per period.
- Divisor latency: `load` to new N takes 1 to N_old cycles, i.e. at the next wrap.

## Configuration
- `CLK_DIV_DUTY50_EN` defined: the negedge flop is present, and odd N gives high for N/2 cycles.
- Undefined: no negedge logic; the design is posedge only. Odd N gives high for floor(N/2) cycles and low for ceil(N/2). Even N is unchanged.

## Structure
- Package `clk_div_pkg`:
  - constant `DIV_MIN` = 2;
  - function `half_div(N)` returning floor(N/2);
  - typedef for the `run_state` enum {IDLE, RUN, STOPPING}.
- Sub-module `clk_div_negedge_ext`: the negedge capture flop with asynchronous reset, plus the OR stage. It is instantiated only under `CLK_DIV_DUTY50_EN`.

## Test plan
- Reset, then `en`=1 with RESET_DIV=5 and the macro defined: `clk_out` period 5 cycles, high 2.5; `tick` every 5 cycles; `running`=1.
- `load` with `div`=4 mid-period of N=5: the current period completes at 5 cycles, then periods are 4 cycles, high 2.
- `load` with `div`=1: `div_err`=1 and the divisor becomes 2. `clk_out` toggles every cycle and `div_err` stays set until `rst`.
- `en` dropped at `cnt`=1 with N=6: the period finishes (high 3, low 3), then `clk_out`=0 and `running`=0. Re-raising `en` restarts with `tick` on the next edge.
- `rst` pulsed mid-high phase with N=7: `clk_out` drops asynchronously, all outputs are at their reset values, and the divisor returns to 5.
- Macro undefined with N=7: high for 3 cycles, low for 4; no negedge activity.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, helpers and run-state encoding for the clk_div_n divider.
package clk_div_pkg;

   localparam int unsigned DIV_MIN = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } run_state;

   function automatic int unsigned half_div(input int unsigned n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clk_div_n_if.sv
// Control/status bundle between a clock-divider client and clk_div_n.
interface clk_div_n_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] div;
   logic             load;
   logic             clk_out;
   logic             tick;
   logic             running;
   logic             div_err;

   modport master (output en, div, load, input clk_out, tick, running, div_err);
   modport slave  (input en, div, load, output clk_out, tick, running, div_err);
endinterface

// File: rtl/clk_div_n_negedge_ext.sv
// Negedge half-cycle extender for odd divisors; only built with CLK_DIV_DUTY50_EN.
module clk_div_negedge_ext (
   input  logic clk,
   input  logic rst,
   input  logic hiPos_i,
   input  logic oddDiv_i,
   output logic clkOut_o
);

   logic hiNeg_q;

   // Even divisors never extend, so the negedge term is held low for them.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         hiNeg_q <= 1'b0;
      end else begin
         hiNeg_q <= hiPos_i & oddDiv_i;
      end
   end

   assign clkOut_o = hiPos_i | hiNeg_q;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with clean start/stop and boundary-only divisor updates.
// Define CLK_DIV_DUTY50_EN for exact 50 % duty on odd divisors (adds a negedge flop).
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int RESET_DIV = 5
) (
   input logic        clk,
   input logic        rst,
   clk_div_n_if.slave bus
);

   localparam logic [1:0]       ST_IDLE     = IDLE;
   localparam logic [1:0]       ST_RUN      = RUN;
   localparam logic [1:0]       ST_STOPPING = STOPPING;
   localparam logic [WIDTH-1:0] DIV_MIN_W   = WIDTH'(DIV_MIN);
   localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] divAct_q, divAct_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pendValid_q, pendValid_d;
   logic             hiPos_q, hiPos_d;
   logic             tick_q, tick_d;
   logic             divErr_q, divErr_d;
   logic             wrap, start, apply, runNext, divLow;
   logic [WIDTH-1:0] halfNext;
   logic             clkOut;

   // A pending divisor is only taken at a period boundary or at start-up, so
   // a load on the wrap edge itself waits for the following wrap.
   always_comb begin
      wrap        = (state_q != ST_IDLE) && (cnt_q == divAct_q - ONE_W);
      start       = (state_q == ST_IDLE) && bus.en;
      apply       = wrap || start;
      divLow      = bus.div < DIV_MIN_W;
      state_d     = state_q;
      cnt_d       = cnt_q;
      divAct_d    = (apply && pendValid_q) ? pend_q : divAct_q;
      pendValid_d = bus.load ? 1'b1 : (apply ? 1'b0 : pendValid_q);
      pend_d      = bus.load ? (divLow ? DIV_MIN_W : bus.div) : pend_q;
      divErr_d    = divErr_q | (bus.load & divLow);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_STOPPING: begin
            if (wrap) begin
               cnt_d   = '0;
               state_d = bus.en ? ST_RUN : ST_IDLE;
            end else begin
               cnt_d   = cnt_q + ONE_W;
               state_d = bus.en ? ST_RUN : ST_STOPPING;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      runNext  = (state_d != ST_IDLE);
      halfNext = WIDTH'(half_div(32'(divAct_d)));
      hiPos_d  = runNext && (cnt_d < halfNext);
      tick_d   = runNext && (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         divAct_q    <= WIDTH'(RESET_DIV);
         pend_q      <= '0;
         pendValid_q <= 1'b0;
         hiPos_q     <= 1'b0;
         tick_q      <= 1'b0;
         divErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         divAct_q    <= divAct_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
         hiPos_q     <= hiPos_d;
         tick_q      <= tick_d;
         divErr_q    <= divErr_d;
      end
   end

`ifdef CLK_DIV_DUTY50_EN
   clk_div_negedge_ext uNegExt (
      .clk      (clk),
      .rst      (rst),
      .hiPos_i  (hiPos_q),
      .oddDiv_i (divAct_q[0]),
      .clkOut_o (clkOut)
   );
`else
   assign clkOut = hiPos_q;
`endif

   assign bus.clk_out = clkOut;
   assign bus.tick    = tick_q;
   assign bus.running = (state_q != ST_IDLE);
   assign bus.div_err = divErr_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: vector table, corner sequences and randomized run vs a period model.
module tb_clk_div_n;

   localparam int WIDTH     = 8;
   localparam int RESET_DIV = 5;
`ifdef CLK_DIV_DUTY50_EN
   localparam bit DUTY50 = 1'b1;
`else
   localparam bit DUTY50 = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   clk_div_n_if #(.WIDTH(WIDTH)) bus ();

   clk_div_n #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       load;
      logic [7:0] div;
      logic       expClk;
      logic       expTick;
      logic       expRun;
   } vec_t;

   vec_t vecs[17];
   int   checks   = 0;
   int   failures = 0;

   // Period-level model: which period slot we are in and which divisor governs it.
   bit   mRunning;
   int   mPhase;
   int   mN;
   int   mPend;
   bit   mPendValid;
   bit   mErr;

   function automatic vec_t mkVec(input logic en, input logic load, input int div,
                                  input logic c, input logic t, input logic r);
      vec_t v;
      v.en = en; v.load = load; v.div = 8'(div);
      v.expClk = c; v.expTick = t; v.expRun = r;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mRunning = 1'b0; mPhase = 0; mN = RESET_DIV;
      mPend = 0; mPendValid = 1'b0; mErr = 1'b0;
   endtask

   task automatic modelStep();
      bit apply = 1'b0;
      if (!mRunning) begin
         if (bus.en) begin
            mRunning = 1'b1; mPhase = 0; apply = 1'b1;
         end
      end else if (mPhase == mN - 1) begin
         mPhase = 0; apply = 1'b1;
         if (!bus.en) mRunning = 1'b0;
      end else begin
         mPhase++;
      end
      if (apply && mPendValid) begin
         mN = mPend; mPendValid = 1'b0;
      end
      if (bus.load) begin
         mPend = (bus.div < 2) ? 2 : int'(bus.div);
         mPendValid = 1'b1;
         if (bus.div < 2) mErr = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic en, input logic load, input logic [7:0] div);
      bus.en = en; bus.load = load; bus.div = div;
   endtask

   // One clk cycle: model advances on the posedge, DUT sampled 1 ns after both edges.
   task automatic cycle();
      logic hiBody, expPos;
      @(posedge clk);
      modelStep();
      hiBody = mRunning && (mPhase < mN / 2);
      expPos = hiBody || (DUTY50 && mRunning && (mN % 2 == 1) && (mPhase == mN / 2));
      #1;
      checkOutput("clk_out_pos", bus.clk_out, expPos);
      checkOutput("tick", bus.tick, mRunning && (mPhase == 0));
      checkOutput("running", bus.running, mRunning);
      checkOutput("div_err", bus.div_err, mErr);
      @(negedge clk);
      #1;
      checkOutput("clk_out_neg", bus.clk_out, hiBody);
   endtask

   task automatic asyncReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_clk_out", bus.clk_out, 1'b0);
      checkOutput("rst_tick", bus.tick, 1'b0);
      checkOutput("rst_running", bus.running, 1'b0);
      checkOutput("rst_div_err", bus.div_err, 1'b0);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   task automatic waitPhase(input string name, input int n, input int ph, input int budget);
      int k = 0;
      while (!(mRunning && mN == n && mPhase == ph) && k < budget) begin
         cycle();
         k++;
      end
      checkOutput(name, (mRunning && mN == n && mPhase == ph), 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'd0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_clk_out", bus.clk_out, 1'b0);
      checkOutput("reset_tick", bus.tick, 1'b0);
      checkOutput("reset_running", bus.running, 1'b0);
      checkOutput("reset_div_err", bus.div_err, 1'b0);
      rst = 1'b0;

      // Start at N=5, load 4 mid-period, drop en at slot 1 of N=4, then restart.
      vecs[0]  = mkVec(0, 0, 0, 0, 0, 0);
      vecs[1]  = mkVec(1, 0, 0, 1, 1, 1);
      vecs[2]  = mkVec(1, 0, 0, 1, 0, 1);
      vecs[3]  = mkVec(1, 1, 4, 0, 0, 1);
      vecs[4]  = mkVec(1, 0, 0, 0, 0, 1);
      vecs[5]  = mkVec(1, 0, 0, 0, 0, 1);
      vecs[6]  = mkVec(1, 0, 0, 1, 1, 1);
      vecs[7]  = mkVec(1, 0, 0, 1, 0, 1);
      vecs[8]  = mkVec(1, 0, 0, 0, 0, 1);
      vecs[9]  = mkVec(1, 0, 0, 0, 0, 1);
      vecs[10] = mkVec(1, 0, 0, 1, 1, 1);
      vecs[11] = mkVec(0, 0, 0, 1, 0, 1);
      vecs[12] = mkVec(0, 0, 0, 0, 0, 1);
      vecs[13] = mkVec(0, 0, 0, 0, 0, 1);
      vecs[14] = mkVec(0, 0, 0, 0, 0, 0);
      vecs[15] = mkVec(0, 0, 0, 0, 0, 0);
      vecs[16] = mkVec(1, 0, 0, 1, 1, 1);

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].en, vecs[i].load, vecs[i].div);
         cycle();
         checkOutput($sformatf("vec%0d_clk", i), bus.clk_out, vecs[i].expClk);
         checkOutput($sformatf("vec%0d_tick", i), bus.tick, vecs[i].expTick);
         checkOutput($sformatf("vec%0d_run", i), bus.running, vecs[i].expRun);
      end

      // Illegal divisor clamps to 2 and leaves a sticky error.
      applyStimulus(1'b1, 1'b1, 8'd1);
      cycle();
      checkOutput("div_err_set", bus.div_err, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      waitPhase("reach_n2", 2, 0, 20);
      repeat (6) cycle();
      checkOutput("div_err_sticky", bus.div_err, 1'b1);

      // Stop request at slot 1 of N=6, finish the period, then restart.
      applyStimulus(1'b1, 1'b1, 8'd6);
      cycle();
      applyStimulus(1'b1, 1'b0, 8'd0);
      waitPhase("reach_n6", 6, 0, 20);
      applyStimulus(1'b0, 1'b0, 8'd0);
      repeat (6) cycle();
      checkOutput("n6_stopped_run", bus.running, 1'b0);
      checkOutput("n6_stopped_clk", bus.clk_out, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      cycle();
      checkOutput("n6_restart_tick", bus.tick, 1'b1);

      // Reset in the high phase of N=7, then confirm the divisor is back to 5.
      applyStimulus(1'b1, 1'b1, 8'd7);
      cycle();
      applyStimulus(1'b1, 1'b0, 8'd0);
      waitPhase("reach_n7", 7, 1, 20);
      checkOutput("n7_high_before_rst", bus.clk_out, 1'b1);
      asyncReset();
      applyStimulus(1'b1, 1'b0, 8'd0);
      repeat (11) cycle();
      waitPhase("back_to_n5", RESET_DIV, 0, 2);

      // Randomized traffic against the model, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
                       8'($urandom_range(0, 13)));
         cycle();
         if ($urandom_range(0, 299) == 0) asyncReset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
